multicycle_controller: RTL

- Main control FSM for the multicycle RV32I datapath.
- Decodes the instruction register fields and drives the ALU's 3-bit ALUControl, operand selects, and all datapath write enables.
- Consumes the ALU Zero flag to resolve beq.
- Adds a memory ready handshake so fetch, load and store can stall on a slow memory.

---
 rtl/multicycle_controller_pkg.sv | 61 ++++++
 rtl/multicycle_controller_alu_op_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
//----------------------------------------------------------------------------
// Module   : multicycle_controller_pkg
// Brief    : Shared encodings for the multicycle RV32I control path and ALU.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] c_OP_STORE = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
   localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
   localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
   localparam logic [6:0] c_OP_JAL   = 7'b1101111;

   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_AND = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_SLT = 3'b101;

   localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
   localparam logic [1:0] c_RES_DATA      = 2'b01;
   localparam logic [1:0] c_RES_ALURESULT = 2'b10;

   localparam logic [1:0] c_SRCA_PC    = 2'b00;
   localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
   localparam logic [1:0] c_SRCA_RS1   = 2'b10;

   localparam logic [1:0] c_SRCB_RS2  = 2'b00;
   localparam logic [1:0] c_SRCB_IMM  = 2'b01;
   localparam logic [1:0] c_SRCB_FOUR = 2'b10;

   localparam logic [1:0] c_IMM_I = 2'b00;
   localparam logic [1:0] c_IMM_S = 2'b01;
   localparam logic [1:0] c_IMM_B = 2'b10;
   localparam logic [1:0] c_IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_op_decoder.sv
//----------------------------------------------------------------------------
// Module   : alu_op_decoder
// Brief    : Maps ALUOp/funct fields to ALUControl and flags unsupported funct3.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_op_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [2:0] o_alucontrol,
   output logic       o_bad_funct
);

   always_comb begin
      o_alucontrol = c_ALU_ADD;
      o_bad_funct  = 1'b0;
      case (i_aluop)
         c_ALUOP_ADD: o_alucontrol = c_ALU_ADD;
         c_ALUOP_SUB: o_alucontrol = c_ALU_SUB;
         c_ALUOP_FUNCT: begin
            case (i_funct3)
               // I-type has no sub; instr[30] there is immediate data
               3'b000:  o_alucontrol = (i_op5 & i_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
               3'b010:  o_alucontrol = c_ALU_SLT;
               3'b110:  o_alucontrol = c_ALU_OR;
               3'b111:  o_alucontrol = c_ALU_AND;
               default: o_bad_funct  = 1'b1;
            endcase
         end
         default: o_alucontrol = c_ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
//----------------------------------------------------------------------------
// Module   : multicycle_controller
// Brief    : Main control FSM for the multicycle RV32I datapath with memory stall.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int STATE_W         = 4,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   logic [STATE_W-1:0] r_state;
   state_t             w_state;
   state_t             w_next;
   state_t             w_fail;
   logic               w_pcupdate;
   logic               w_branch;
   logic               w_irwrite;
   logic               w_regwrite;
   logic               w_memwrite;
   logic               w_illegal;
   logic [1:0]         w_aluop;
   logic               w_bad_funct;

   assign w_state = state_t'(r_state[3:0]);
   assign w_fail  = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

   always_ff @(posedge clk) begin
      if (reset) r_state <= STATE_W'(S_FETCH);
      else       r_state <= STATE_W'(w_next);
   end

   always_comb begin
      w_next     = w_state;
      w_pcupdate = 1'b0;
      w_branch   = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      w_illegal  = 1'b0;
      w_aluop    = c_ALUOP_ADD;
      AdrSrc     = 1'b0;
      ResultSrc  = c_RES_ALUOUT;
      ALUSrcA    = c_SRCA_PC;
      ALUSrcB    = c_SRCB_RS2;
      case (w_state)
         S_FETCH: begin
            ALUSrcB    = c_SRCB_FOUR;
            ResultSrc  = c_RES_ALURESULT;
            w_irwrite  = MemReady;
            w_pcupdate = MemReady;
            w_next     = MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = c_SRCA_OLDPC;
            ALUSrcB = c_SRCB_IMM;
            case (op)
               c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
               c_OP_RTYPE:            w_next = S_EXECUTER;
               c_OP_ITYPE:            w_next = S_EXECUTEI;
               c_OP_BEQ:              w_next = S_BEQ;
               c_OP_JAL:              w_next = S_JAL;
               default:               w_next = w_fail;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = c_SRCA_RS1;
            ALUSrcB = c_SRCB_IMM;
            w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            w_next = MemReady ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc  = c_RES_DATA;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
            w_next     = MemReady ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = c_SRCA_RS1;
            w_aluop = c_ALUOP_FUNCT;
            w_next  = w_bad_funct ? w_fail : S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = c_SRCA_RS1;
            ALUSrcB = c_SRCB_IMM;
            w_aluop = c_ALUOP_FUNCT;
            w_next  = w_bad_funct ? w_fail : S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA  = c_SRCA_RS1;
            w_aluop  = c_ALUOP_SUB;
            w_branch = 1'b1;
            w_next   = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA    = c_SRCA_OLDPC;
            ALUSrcB    = c_SRCB_FOUR;
            w_pcupdate = 1'b1;
            w_next     = S_ALUWB;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
            w_next    = S_TRAP;
         end
         default: w_next = S_FETCH;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .i_aluop      (w_aluop),
      .i_funct3     (funct3),
      .i_funct7b5   (funct7b5),
      .i_op5        (op[5]),
      .o_alucontrol (ALUControl),
      .o_bad_funct  (w_bad_funct)
   );

   always_comb begin
      ImmSrc = c_IMM_I;
      case (op)
         c_OP_STORE: ImmSrc = c_IMM_S;
         c_OP_BEQ:   ImmSrc = c_IMM_B;
         c_OP_JAL:   ImmSrc = c_IMM_J;
         default:    ImmSrc = c_IMM_I;
      endcase
   end

   // Reset gates every write strobe so an abandoned instruction cannot commit
   assign PCWrite  = ~reset & ((w_branch & Zero) | w_pcupdate);
   assign IRWrite  = ~reset & w_irwrite;
   assign RegWrite = ~reset & w_regwrite;
   assign MemWrite = ~reset & w_memwrite;
   assign Illegal  = ~reset & w_illegal;

endmodule

`default_nettype wire
